// File: rtl/press_decoder_pkg.sv
// press_decoder_pkg: shared state encoding, default timing constants
// and counter-width helper for the push-button gesture decoder.
package press_decoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PRESSED     = 3'd1,
    S_LONG_HELD   = 3'd2,
    S_WAIT_SECOND = 3'd3,
    S_PRESSED2    = 3'd4
  } state_t;

  localparam int DEF_LONG_CYCLES   = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;
  localparam int DEF_GAP_CYCLES    = 12_500_000;

  // One bit above clog2 of the largest count, so the saturating
  // counter never sits at all-ones while a compare is pending.
  function automatic int cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/press_timer.sv
// press_timer: saturating up-counter, cleared on request, with a
// terminal-count compare against a per-state limit.
module press_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  // Count while enabled; clear on request; stop at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign hit = enable && (count == limit);

endmodule

// File: rtl/press_decoder.sv
// press_decoder: classifies debounced button strobes into short,
// long, repeat and (with PRESS_DECODER_DOUBLE_PRESS_EN) double presses.
module press_decoder
  import press_decoder_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int CNT_W         = cnt_w(DEF_LONG_CYCLES,
                                      DEF_REPEAT_CYCLES,
                                      DEF_GAP_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic button_down,
  input  logic button_up,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic double_press,
  output logic held
);

  // Compare values account for the registered outputs: the decision
  // is taken one cycle before the pulse becomes visible. PRESSED and
  // WAIT_SECOND start counting one cycle after the strobe, LONG_HELD
  // starts counting on the long_press cycle itself.
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES - 2);

  state_t state;
  state_t next_state;

  logic             dn;
  logic             up;
  logic             hit;
  logic             clear;
  logic             enable;
  logic [CNT_W-1:0] limit;

  logic short_n;
  logic long_n;
  logic rep_n;
  logic dbl_n;
  logic held_n;

  // Simultaneous down and up cancel each other out.
  assign dn = button_down & ~button_up;
  assign up = button_up & ~button_down;

  assign enable = (state != S_IDLE);
  assign clear  = (next_state != state) || rep_n;

  // Select the terminal count that matters in the current state.
  always_comb begin
    limit = GAP_LIM;
    case (state)
      S_PRESSED:   limit = LONG_LIM;
      S_LONG_HELD: limit = REP_LIM;
      default:     limit = GAP_LIM;
    endcase
  end

  press_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .limit  (limit),
    .hit    (hit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; a release always wins over a timer hit.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (dn) next_state = S_PRESSED;
      end
      S_PRESSED: begin
        if (up) begin
`ifdef PRESS_DECODER_DOUBLE_PRESS_EN
          next_state = S_WAIT_SECOND;
`else
          next_state = S_IDLE;
`endif
        end else if (hit) begin
          next_state = S_LONG_HELD;
        end
      end
      S_LONG_HELD: begin
        if (up) next_state = S_IDLE;
      end
`ifdef PRESS_DECODER_DOUBLE_PRESS_EN
      S_WAIT_SECOND: begin
        if (dn) next_state = S_PRESSED2;
        else if (hit) next_state = S_IDLE;
      end
      S_PRESSED2: begin
        if (up) next_state = S_IDLE;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Event decode for the following cycle.
  always_comb begin
    short_n = 1'b0;
    long_n  = 1'b0;
    rep_n   = 1'b0;
    dbl_n   = 1'b0;
    case (state)
      S_PRESSED: begin
`ifndef PRESS_DECODER_DOUBLE_PRESS_EN
        short_n = up;
`endif
        long_n = !up && hit;
      end
      S_LONG_HELD: begin
        rep_n = !up && hit;
      end
`ifdef PRESS_DECODER_DOUBLE_PRESS_EN
      S_WAIT_SECOND: begin
        short_n = !dn && hit;
      end
      S_PRESSED2: begin
        dbl_n = up;
      end
`endif
      default: ;
    endcase
    held_n = (next_state == S_PRESSED) ||
             (next_state == S_LONG_HELD) ||
             (next_state == S_PRESSED2);
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
    end else begin
      short_press  <= short_n;
      long_press   <= long_n;
      repeat_tick  <= rep_n;
      double_press <= dbl_n;
      held         <= held_n;
    end
  end

endmodule

// File: tb/tb_press_decoder.sv
// tb_press_decoder: directed gesture scenarios checked every cycle
// against a timestamp-based gesture model plus literal event times.
module tb_press_decoder;

  localparam int L = 8;
  localparam int R = 4;
  localparam int G = 6;
`ifdef PRESS_DECODER_DOUBLE_PRESS_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic button_down;
  logic button_up;
  logic short_press;
  logic long_press;
  logic repeat_tick;
  logic double_press;
  logic held;

  always #5 clk = ~clk;

  press_decoder #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R),
    .GAP_CYCLES    (G),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_down  (button_down),
    .button_up    (button_up),
    .short_press  (short_press),
    .long_press   (long_press),
    .repeat_tick  (repeat_tick),
    .double_press (double_press),
    .held         (held)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  bit chk = 1'b0;

  // {short, long, repeat, double, held}
  logic [4:0] exp_o;
  logic [4:0] pend;
  logic [4:0] act;

  int first_short;
  int first_long;
  int first_dbl;
  int n_rep;
  int rep_last;
  int held_fall;
  logic prev_held;

  // Gesture model: 0 idle, 1 down, 2 long held, 3 gap, 4 second down
  int phase;
  int d;
  int u;

  task automatic model(input int t, input bit bd, input bit bu);
    bit a;
    bit b;
    a = bd && !bu;
    b = bu && !bd;
    pend = '0;
    case (phase)
      0: if (a) begin phase = 1; d = t; end
      1: begin
        if (b) begin
          if (DP) begin phase = 3; u = t; end
          else begin pend[4] = 1'b1; phase = 0; end
        end else if (t + 1 == d + L) begin
          pend[3] = 1'b1;
          phase = 2;
        end
      end
      2: begin
        if (b) phase = 0;
        else if (t + 1 > d + L && (t + 1 - d - L) % R == 0)
          pend[2] = 1'b1;
      end
      3: begin
        if (a) phase = 4;
        else if (t + 1 == u + G) begin pend[4] = 1'b1; phase = 0; end
      end
      4: if (b) begin pend[1] = 1'b1; phase = 0; end
      default: phase = 0;
    endcase
    pend[0] = (phase == 1) || (phase == 2) || (phase == 4);
  endtask

  // Per-cycle comparison against the model, plus event-time capture.
  always @(negedge clk) begin
    if (chk) begin
      act = {short_press, long_press, repeat_tick, double_press, held};
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL cycle%0d outputs act=%b exp=%b", cyc, act, exp_o);
      end
      if (short_press && first_short < 0) first_short = cyc;
      if (long_press && first_long < 0) first_long = cyc;
      if (double_press && first_dbl < 0) first_dbl = cyc;
      if (repeat_tick) begin n_rep++; rep_last = cyc; end
      if (prev_held && !held) held_fall = cyc;
      prev_held = held;
    end
  end

  task automatic lit(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, a, e);
    end
  endtask

  task automatic run(input int n, input int dn0, input int dn1,
                     input int up0, input int up1, input int rstc);
    chk = 1'b0;
    button_down = 1'b0;
    button_up = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    phase = 0;
    pend = '0;
    first_short = -1;
    first_long = -1;
    first_dbl = -1;
    n_rep = 0;
    rep_last = -1;
    held_fall = -1;
    prev_held = 1'b0;
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      cyc = t;
      exp_o = pend;
      if (t == rstc) begin
        reset = 1'b1;
        button_down = 1'b0;
        button_up = 1'b0;
        exp_o = '0;
        pend = '0;
        phase = 0;
      end else begin
        reset = 1'b0;
        button_down = (t == dn0) || (t == dn1);
        button_up = (t == up0) || (t == up1);
        model(t, button_down, button_up);
      end
      chk = 1'b1;
    end
    @(posedge clk);
    #1;
    chk = 1'b0;
    reset = 1'b0;
    button_down = 1'b0;
    button_up = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    button_down = 1'b0;
    button_up = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit("reset_outputs",
        {27'd0, short_press, long_press, repeat_tick, double_press, held},
        0);

    // Short press, release at 3.
    run(12, 0, -1, 3, -1, -1);
    lit("s1_short", first_short, DP ? 9 : 4);
    lit("s1_long", first_long, -1);
    lit("s1_held_fall", held_fall, 4);

    // Release one cycle before the long threshold.
    run(16, 0, -1, 7, -1, -1);
    lit("s2_short", first_short, DP ? 13 : 8);
    lit("s2_long", first_long, -1);

    // Release exactly at the long threshold.
    run(16, 0, -1, 8, -1, -1);
    lit("s3_long", first_long, 8);
    lit("s3_short", first_short, -1);

    // Long hold with auto-repeat, release at 21.
    run(26, 0, -1, 21, -1, -1);
    lit("s4_long", first_long, 8);
    lit("s4_nrep", n_rep, 3);
    lit("s4_rep_last", rep_last, 20);
    lit("s4_held_fall", held_fall, 22);

    // Second press inside the gap.
    run(14, 0, 5, 2, 7, -1);
    lit("s5_dbl", first_dbl, DP ? 8 : -1);
    lit("s5_short", first_short, DP ? -1 : 3);

    // Reset mid-press, stale release, then a fresh press.
    run(22, 0, 10, 6, 12, 4);
    lit("s6_short", first_short, DP ? 18 : 13);
    lit("s6_long", first_long, -1);

    // Down and up together in IDLE.
    run(10, 2, -1, 2, -1, -1);
    lit("s7_short", first_short, -1);
    lit("s7_held_fall", held_fall, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
